uart_apb_ctrl: RTL and testbench

UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

---
 rtl/uart_apb_pkg.sv | 22 ++
 rtl/uart_apb_arb.sv | 42 ++++
 rtl/uart_apb_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_apb_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared types for the UART APB controller: FSM states, UART register map and grant encoding.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  localparam logic [1:0] ADDR_BAUD = 2'd0;
  localparam logic [1:0] ADDR_RX   = 2'd1;
  localparam logic [1:0] ADDR_TX   = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CFG,
    GNT_RX,
    GNT_TX
  } gnt_e;

endpackage

// File: rtl/uart_apb_arb.sv
// Requester arbiter: baud rewrite has absolute priority, RX and TX share the bus round-robin.
module uart_apb_arb
  import uart_apb_pkg::*;
(
  input  logic pclk,
  input  logic presetn,
  input  logic en_i,
  input  logic cfg_req_i,
  input  logic rx_req_i,
  input  logic tx_req_i,
  output gnt_e gnt_o
);

  // Set after an RX grant so TX wins the next contested slot.
  logic tx_pri_q;
  logic tx_pri_d;

  always_comb begin
    gnt_o    = GNT_NONE;
    tx_pri_d = tx_pri_q;
    if (en_i) begin
      if (cfg_req_i) begin
        gnt_o = GNT_CFG;
      end else if (rx_req_i && (!tx_req_i || !tx_pri_q)) begin
        gnt_o    = GNT_RX;
        tx_pri_d = 1'b1;
      end else if (tx_req_i) begin
        gnt_o    = GNT_TX;
        tx_pri_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_pri_q <= 1'b0;
    end else begin
      tx_pri_q <= tx_pri_d;
    end
  end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB master that programs a UART: baud init after reset, then arbitrated baud/TX writes and RX reads.
module uart_apb_ctrl
  import uart_apb_pkg::*;
#(
  parameter int                  BITWIDTH  = 8,
  parameter int                  TIMEOUT   = 16,
  parameter logic [BITWIDTH-1:0] BAUD_INIT = 8'd0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                cfg_valid,
  input  logic [BITWIDTH-1:0] cfg_baud,
  output logic                cfg_ready,
  input  logic                tx_valid,
  input  logic [BITWIDTH-1:0] tx_data,
  output logic                tx_ready,
  output logic                rx_valid,
  output logic [BITWIDTH-1:0] rx_data,
  input  logic                tx_rdy_i,
  input  logic                rx_rdy_i,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [1:0]          paddr,
  output logic [BITWIDTH-1:0] pwdata,
  input  logic [BITWIDTH-1:0] prdata,
  input  logic                pready,
  output logic                err_o,
  input  logic                err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  gnt_e             gnt;

  uart_apb_arb u_arb (
    .pclk      (pclk),
    .presetn   (presetn),
    .en_i      (state_q == ST_IDLE),
    .cfg_req_i (cfg_valid),
    .rx_req_i  (rx_rdy_i),
    .tx_req_i  (tx_valid && tx_rdy_i),
    .gnt_o     (gnt)
  );

  assign cfg_ready = (gnt == GNT_CFG);
  assign tx_ready  = (gnt == GNT_TX);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      err_o    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // A timeout below overrides this clear in the same cycle.
      if (err_clr) err_o <= 1'b0;
      case (state_q)
        ST_INIT: begin
          state_q <= ST_SETUP;
          psel    <= 1'b1;
          paddr   <= ADDR_BAUD;
          pwrite  <= 1'b1;
          pwdata  <= BAUD_INIT;
        end
        ST_IDLE: begin
          if (gnt != GNT_NONE) begin
            state_q <= ST_SETUP;
            psel    <= 1'b1;
          end
          case (gnt)
            GNT_CFG: begin
              paddr  <= ADDR_BAUD;
              pwrite <= 1'b1;
              pwdata <= cfg_baud;
            end
            GNT_RX: begin
              paddr  <= ADDR_RX;
              pwrite <= 1'b0;
              pwdata <= '0;
            end
            GNT_TX: begin
              paddr  <= ADDR_TX;
              pwrite <= 1'b1;
              pwdata <= tx_data;
            end
            default: ;
          endcase
        end
        ST_SETUP: begin
          state_q <= ST_ACCESS;
          penable <= 1'b1;
          cnt_q   <= CNT_W'(1);
        end
        ST_ACCESS: begin
          if (pready) begin
            state_q <= ST_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            cnt_q   <= '0;
            if (!pwrite) begin
              rx_valid <= 1'b1;
              rx_data  <= prdata;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            state_q <= ST_IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            cnt_q   <= '0;
            err_o   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: transaction-age reference model checked every cycle plus directed literal checks.
module tb_uart_apb_ctrl;

  localparam int         TMO  = 16;
  localparam logic [7:0] BAUD = 8'h5A;

  logic       pclk = 1'b0;
  logic       presetn;
  logic       cfg_valid, cfg_ready, tx_valid, tx_ready, rx_valid;
  logic       tx_rdy_i, rx_rdy_i, psel, penable, pwrite, err_o, err_clr;
  logic       pready = 1'b0;
  logic [7:0] cfg_baud, tx_data, rx_data, pwdata, prdata;
  logic [1:0] paddr;

  int n_cmp = 0;
  int n_bad = 0;
  int resp_wait = 0;
  bit resp_tie  = 1'b1;
  int acc_seen  = 0;

  always #5 pclk = ~pclk;

  uart_apb_ctrl #(.BITWIDTH(8), .TIMEOUT(TMO), .BAUD_INIT(BAUD)) dut (
    .pclk(pclk), .presetn(presetn),
    .cfg_valid(cfg_valid), .cfg_baud(cfg_baud), .cfg_ready(cfg_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_rdy_i(tx_rdy_i), .rx_rdy_i(rx_rdy_i),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready),
    .err_o(err_o), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Completer: pready after resp_wait wait states in ACCESS, or always high when tied.
  always @(negedge pclk) begin
    if (psel && penable) acc_seen++;
    else acc_seen = 0;
    if (resp_tie) pready = 1'b1;
    else pready = psel && penable && (acc_seen == resp_wait + 1);
  end

  // Reference model: one transfer in flight, tracked by its age in cycles since the grant.
  bit         m_init, m_busy, m_wr, m_err, m_rxv, m_txpri;
  int         m_age;
  logic [1:0] m_addr;
  logic [7:0] m_wd, m_rxd;

  always @(negedge pclk) begin : cmp
    int g;
    bit idle, rxq, txq, e_psel, e_pen, to;
    #3;
    if (!presetn) begin
      m_init = 1; m_busy = 0; m_age = 0; m_wr = 0; m_addr = 0; m_wd = 0;
      m_err = 0; m_rxv = 0; m_rxd = 0; m_txpri = 0;
    end
    idle = presetn && !m_init && !m_busy;
    rxq  = rx_rdy_i;
    txq  = tx_valid && tx_rdy_i;
    g = 0;
    if (idle) begin
      if (cfg_valid) g = 1;
      else if (rxq && txq) g = m_txpri ? 3 : 2;
      else if (rxq) g = 2;
      else if (txq) g = 3;
    end
    e_psel = m_busy;
    e_pen  = m_busy && (m_age >= 2);
    check("psel", psel, e_psel);
    check("penable", penable, e_pen);
    check("cfg_ready", cfg_ready, g == 1);
    check("tx_ready", tx_ready, g == 3);
    check("rx_valid", rx_valid, m_rxv);
    check("rx_data", rx_data, m_rxd);
    check("err_o", err_o, m_err);
    if (e_psel || !presetn) begin
      check("paddr", paddr, m_addr);
      check("pwrite", pwrite, m_wr);
      if (m_wr || !presetn) check("pwdata", pwdata, m_wd);
    end
    to = 0;
    if (presetn) begin
      m_rxv = 0;
      if (m_init) begin
        m_init = 0; m_busy = 1; m_age = 1; m_addr = 0; m_wr = 1; m_wd = BAUD;
      end else if (m_busy) begin
        if (m_age == 1) m_age = 2;
        else if (pready) begin
          m_busy = 0;
          if (!m_wr) begin m_rxv = 1; m_rxd = prdata; end
        end else if (m_age - 1 == TMO) begin
          m_busy = 0; to = 1;
        end else m_age++;
      end else if (g != 0) begin
        m_busy = 1; m_age = 1;
        case (g)
          1: begin m_addr = 0; m_wr = 1; m_wd = cfg_baud; end
          2: begin m_addr = 1; m_wr = 0; m_wd = 0; m_txpri = 1; end
          default: begin m_addr = 2; m_wr = 1; m_wd = tx_data; m_txpri = 0; end
        endcase
      end
      if (to) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  task cyc();
    @(negedge pclk);
    #2;
  endtask

  task wait_tx_grant(output bit got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (tx_ready) got = 1;
      else cyc();
    end
  endtask

  // Issue one RX read and follow it until the bus is released; returns ACCESS count and rx pulse seen.
  task run_read(output int acc, output bit saw_rx);
    bit done;
    rx_rdy_i = 1;
    cyc();
    rx_rdy_i = 0;
    acc = 0; saw_rx = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      cyc();
      if (rx_valid) saw_rx = 1;
      if (psel && penable) acc++;
      else if (!psel) done = 1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit  got, saw_rx;
    int  acc;
    int  seq[$];
    int  exp_seq[8] = '{1, 2, 1, 2, 0, 1, 2, 1};

    presetn = 0; cfg_valid = 0; cfg_baud = 0; tx_valid = 0; tx_data = 0;
    tx_rdy_i = 0; rx_rdy_i = 0; prdata = 0; err_clr = 0;
    repeat (3) cyc();
    check("rst_psel", psel, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_err", err_o, 0);

    // Baud init write with pready tied high.
    presetn = 1;
    cyc();
    check("init_setup_psel", psel, 1);
    check("init_setup_pen", penable, 0);
    check("init_addr", paddr, 0);
    check("init_pwrite", pwrite, 1);
    check("init_pwdata", pwdata, 8'h5A);
    cyc();
    check("init_access_pen", penable, 1);
    cyc();
    check("init_idle_psel", psel, 0);

    // TX blocked by tx_rdy_i, then granted; later input changes must not leak.
    tx_valid = 1; tx_data = 8'hA5; tx_rdy_i = 0;
    repeat (3) begin
      cyc();
      check("tx_blocked_ready", tx_ready, 0);
    end
    tx_rdy_i = 1;
    wait_tx_grant(got);
    check("tx_grant_seen", got, 1);
    cyc();
    tx_valid = 0; tx_data = 8'hFF; tx_rdy_i = 0;
    check("tx_setup_addr", paddr, 2);
    check("tx_setup_pwdata", pwdata, 8'hA5);
    cyc();
    check("tx_access_pwdata", pwdata, 8'hA5);
    cyc();

    // RX/TX round-robin with a baud rewrite injected mid-stream.
    rx_rdy_i = 1; tx_valid = 1; tx_rdy_i = 1; tx_data = 8'h11; prdata = 8'h77;
    for (int i = 0; i < 24; i++) begin
      cyc();
      if (psel && !penable) begin
        seq.push_back(int'(paddr));
        if (paddr == 2'd0) begin
          check("cfg_pwdata", pwdata, 8'h33);
          cfg_valid = 0;
        end
      end
      if (i == 10) begin cfg_valid = 1; cfg_baud = 8'h33; end
    end
    rx_rdy_i = 0; tx_valid = 0; cfg_valid = 0;
    check("rr_count", seq.size(), 8);
    for (int k = 0; k < 8 && k < seq.size(); k++) check("rr_order", seq[k], exp_seq[k]);
    repeat (3) cyc();

    // Read with three wait states.
    resp_tie = 0; resp_wait = 3; prdata = 8'h3C;
    run_read(acc, saw_rx);
    check("rd3_access_cycles", acc, 4);
    check("rd3_rx_valid", saw_rx, 1);
    check("rd3_rx_data", rx_data, 8'h3C);
    cyc();
    check("rd3_pulse_len", rx_valid, 0);
    cyc();

    // Timeout: no pready at all.
    resp_wait = 1000;
    run_read(acc, saw_rx);
    check("to_access_cycles", acc, TMO);
    check("to_err", err_o, 1);
    check("to_no_rx", saw_rx, 0);
    err_clr = 1;
    cyc();
    err_clr = 0;
    check("to_err_cleared", err_o, 0);
    cyc();

    // Timeout while clear is held: set wins, then clear takes effect.
    err_clr = 1;
    run_read(acc, saw_rx);
    check("setwins_err", err_o, 1);
    cyc();
    check("setwins_cleared", err_o, 0);
    err_clr = 0;
    cyc();

    // pready on the last allowed ACCESS cycle completes normally.
    resp_wait = TMO - 1; prdata = 8'hC3;
    run_read(acc, saw_rx);
    check("edge_access_cycles", acc, TMO);
    check("edge_rx_valid", saw_rx, 1);
    check("edge_rx_data", rx_data, 8'hC3);
    check("edge_err", err_o, 0);
    cyc();

    // Reset during ACCESS abandons the transfer; init write repeats.
    resp_wait = 1000;
    tx_valid = 1; tx_rdy_i = 1; tx_data = 8'h42;
    wait_tx_grant(got);
    check("rst_tx_grant", got, 1);
    cyc();
    tx_valid = 0; tx_rdy_i = 0;
    cyc();
    cyc();
    check("pre_rst_penable", penable, 1);
    presetn = 0;
    #1;
    check("rst_mid_psel", psel, 0);
    check("rst_mid_penable", penable, 0);
    cyc();
    cyc();
    resp_tie = 1;
    presetn = 1;
    cyc();
    check("reinit_psel", psel, 1);
    check("reinit_addr", paddr, 0);
    check("reinit_pwdata", pwdata, 8'h5A);
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
